regfile_mp_scoreboard: RTL and testbench

//  Parametrised multi-port register file for the pipelined CPU: NUM_RD combinational read ports,
//  two write ports (WB and a second retire/load path), and a per-register busy scoreboard.

---
 rtl/regfile_mp_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - multi-port register file with per-register busy scoreboard
//
// Purpose: NUM_RD combinational read ports, two write ports (wr1 has priority on an
// address collision) and a busy bit per register. ID sets a bit on issue and a write
// clears it. Optional same-cycle write-to-read forwarding is compiled in with
// `define REGFILE_BYPASS_EN.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   rd_addr/rd_data    packed read ports, port k at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
//   rd_busy            per read port: addressed register has a pending write
//   wr0_*, wr1_*       write ports (wr1 wins on the same address)
//   iss_en, iss_addr   mark a register busy
//   busy_vec           registered scoreboard, bit i = register i busy
module regfile_mp_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              wr0_ok;
  logic              wr1_ok;

  // Register 0 is hardwired when ZR, so writes to it are simply dropped.
  assign wr0_ok = wr0_en && !(ZR && (wr0_addr == '0));
  assign wr1_ok = wr1_en && !(ZR && (wr1_addr == '0));

  // Clears applied first, then the issue set, so a new producer overrides a retiring one.
  always_comb begin
    busy_next = busy;
    if (wr0_en) busy_next[wr0_addr] = 1'b0;
    if (wr1_en) busy_next[wr1_addr] = 1'b0;
    if (iss_en) busy_next[iss_addr] = 1'b1;
    if (ZR)     busy_next[0]        = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      // Later assignment wins, giving wr1 priority on a same-address double write.
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = regs[a];
      b = busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wr0_en && (wr0_addr == a)) begin
        d = wr0_data;
        b = 1'b0;
      end
      if (wr1_en && (wr1_addr == a)) begin
        d = wr1_data;
        b = 1'b0;
      end
`endif
      // Zero register override comes last so forwarding can never leak into r0.
      if (ZR && (a == '0)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k]                  = b;
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb/tb_regfile_mp_scoreboard.sv - directed self-checking bench for regfile_mp_scoreboard
module tb_regfile_mp_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en, wr1_en, iss_en;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

  regfile_mp_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    reset = 0; rd_addr = '0;
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    iss_en = 0; iss_addr = 0;
    step(); step();
    reset = 1;

    // 1: reset state, then mid-use reset
    rd(5'd1, 5'd31);
    check("rst_busy_vec", busy_vec, 0);
    check("rst_r1", rd_data[31:0], 0);
    check("rst_r31", rd_data[63:32], 0);
    wr0_en = 1; wr0_addr = 1; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 2; wr1_data = 32'h22;
    iss_en = 1; iss_addr = 6;
    step(); idle();
    rd(5'd1, 5'd2);
    check("pre_rst_r1", rd_data[31:0], 32'h11);
    check("pre_rst_r2", rd_data[63:32], 32'h22);
    check("pre_rst_busy", busy_vec, 32'h40);
    reset = 0; step(); reset = 1;
    rd(5'd1, 5'd2);
    check("post_rst_r1", rd_data[31:0], 0);
    check("post_rst_r2", rd_data[63:32], 0);
    check("post_rst_busy", busy_vec, 0);

    // 2: write/read, r0 hardwired
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    step(); idle();
    rd(5'd5, 5'd0);
    check("r5_data", rd_data[31:0], 32'hDEADBEEF);
    check("r5_busy", rd_busy[0], 0);
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'h1234;
    step(); idle();
    rd(5'd0, 5'd0);
    check("r0_zero", rd_data[31:0], 0);

    // 3: port priority, issue beats clear
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h1111;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h2222;
    step(); idle();
    rd(5'd7, 5'd0);
    check("r7_wr1_prio", rd_data[31:0], 32'h2222);
    iss_en = 1; iss_addr = 7;
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h3333;
    step(); idle();
    rd(5'd7, 5'd0);
    check("r7_busy_set_wins", busy_vec[7], 1);
    check("r7_rd_busy", rd_busy[0], 1);
    check("r7_data_written", rd_data[31:0], 32'h3333);

    // 4: scoreboard set/clear, no look-ahead, repeated issue, r0 issue
    iss_en = 1; iss_addr = 3;
    rd(5'd0, 5'd3);
    check("r3_no_lookahead", busy_vec[3], 0);
    step();
    step(); idle();
    rd(5'd0, 5'd3);
    check("r3_busy_after_2iss", rd_busy[1], 1);
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'hA5;
    step(); idle();
    rd(5'd0, 5'd3);
    check("r3_busy_cleared", rd_busy[1], 0);
    check("r3_data", rd_data[63:32], 32'hA5);
    iss_en = 1; iss_addr = 0;
    step(); idle();
    check("r0_never_busy", busy_vec[0], 0);
    check("busy_vec_only_r7", busy_vec, 32'h80);

    // 5: same-cycle write/read on r9 (busy beforehand)
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h0BAD;
    iss_en = 1; iss_addr = 9;
    step(); idle();
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'hCAFE;
    rd(5'd0, 5'd9);
`ifdef REGFILE_BYPASS_EN
    check("r9_bypass_data", rd_data[63:32], 32'hCAFE);
    check("r9_bypass_busy", rd_busy[1], 0);
`else
    check("r9_old_data", rd_data[63:32], 32'h0BAD);
    check("r9_old_busy", rd_busy[1], 1);
`endif
    step(); idle();
    rd(5'd0, 5'd9);
    check("r9_new_data", rd_data[63:32], 32'hCAFE);
    check("r9_new_busy", rd_busy[1], 0);

    // 6: mid-run reset overrides pending write and issue
    iss_en = 1; iss_addr = 2;
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'h55;
    step(); idle();
    rd(5'd4, 5'd2);
    check("r4_pre", rd_data[31:0], 32'h55);
    check("r2_busy_pre", rd_busy[1], 1);
    reset = 0;
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'h77;
    iss_en = 1; iss_addr = 4;
    step(); idle(); reset = 1;
    rd(5'd4, 5'd7);
    check("r4_after_rst", rd_data[31:0], 0);
    check("r7_after_rst", rd_data[63:32], 0);
    check("busy_after_rst", busy_vec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
